// File: rtl/rv32i_hazard_unit.sv
// Stall/flush controller for the five-stage RV32I pipeline: load-use, taken-branch squash, MEM load wait with timeout.
// Define RV32I_HAZARD_PERF_EN to build the event counters; otherwise the perf ports are tied to zero.
module rv32i_hazard_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_memread_i,
    input  logic        ex_branch_taken_i,
    input  logic        mem_load_valid_i,
    input  logic        dmem_rvalid_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_stall_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_stall_o,
    output logic        mem_wb_flush_o,
    output logic        dmem_timeout_o,
    output logic [31:0] perf_load_use_o,
    output logic [31:0] perf_mem_wait_o,
    output logic [31:0] perf_flush_o
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        load_use, timeout_now, mem_stall;

    always_comb begin
        load_use = ex_memread_i && (ex_rd_addr_i != '0) &&
                   ((id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                    (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i)));
        timeout_now = (state_q == MEM_WAIT) && (TIMEOUT_CYCLES != 0) &&
                      (cnt_q == TO_LAST) && !dmem_rvalid_i;
        mem_stall = mem_load_valid_i && !dmem_rvalid_i && !timeout_now;

        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_flush_o = mem_stall || timeout_now;
        dmem_timeout_o = timeout_now;

        if (mem_stall) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
        end else if (ex_branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (load_use) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                end
            end
            // !mem_stall here covers rvalid, load gone, or timeout
            MEM_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (!mem_stall) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef RV32I_HAZARD_PERF_EN
    logic        lu_evt, fl_evt;
    logic [31:0] lu_cnt_q, mw_cnt_q, fl_cnt_q;

    assign lu_evt = load_use && !mem_stall && !ex_branch_taken_i;
    assign fl_evt = ex_branch_taken_i && !mem_stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lu_cnt_q <= '0;
            mw_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            if (lu_evt)    lu_cnt_q <= lu_cnt_q + 32'd1;
            if (mem_stall) mw_cnt_q <= mw_cnt_q + 32'd1;
            if (fl_evt)    fl_cnt_q <= fl_cnt_q + 32'd1;
        end
    end

    assign perf_load_use_o = lu_cnt_q;
    assign perf_mem_wait_o = mw_cnt_q;
    assign perf_flush_o    = fl_cnt_q;
`else
    assign perf_load_use_o = '0;
    assign perf_mem_wait_o = '0;
    assign perf_flush_o    = '0;
`endif

endmodule

// File: doc/rv32i_hazard_unit.md
# rv32i_hazard_unit

Pipeline hazard controller for the five-stage RV32I core: sits beside the ID/EX and EX/MEM pipeline registers and produces the stall and flush strobes that keep the EX-stage forwarding selects valid. Detects load-use hazards in ID, squashes wrong-path instructions on taken branches, and freezes the pipeline while a data-memory load in MEM waits for its response, with a bounded-wait timeout. Outputs drive PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables and clears.

## Interface
- TIMEOUT_CYCLES, 256: max MEM_WAIT cycles before abort; 0 disables timeout; range 0..65535
- clk_i  input  1  core clock
- rst_ni  input  1  reset; asynchronous, active-low
- id_rs1_addr_i / id_rs2_addr_i  input  5 each  source registers of instruction in ID
- id_uses_rs1_i / id_uses_rs2_i  input  1 each  ID instruction actually reads rs1/rs2
- ex_rd_addr_i  input  5  destination of instruction in EX
- ex_memread_i  input  1  EX instruction is a valid load
- ex_branch_taken_i  input  1  EX resolved a taken branch/jump (valid instr only)
- mem_load_valid_i  input  1  valid load occupying MEM, request issued
- dmem_rvalid_i  input  1  load data returned this cycle
- pc_stall_o  output  1  hold PC
- if_id_stall_o / if_id_flush_o  output  1 each  hold / clear IF/ID
- id_ex_stall_o / id_ex_flush_o  output  1 each  hold / insert bubble into ID/EX
- ex_mem_stall_o  output  1  hold EX/MEM
- mem_wb_flush_o  output  1  insert bubble into MEM/WB
- dmem_timeout_o  output  1  one-cycle pulse, load aborted
- perf_load_use_o / perf_mem_wait_o / perf_flush_o  output  32 each  event counters

## Operation
- load_use = ex_memread_i && ex_rd!=0 && ((id_uses_rs1_i && id_rs1==ex_rd) || (id_uses_rs2_i && id_rs2==ex_rd)). x0 never hazards.
- mem_stall = mem_load_valid_i && !dmem_rvalid_i && !timeout_now.
- Priority (highest first):
  - mem_stall: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush all 1; no flushes of IF/ID or ID/EX; branch and load-use suppressed (EX held, re-evaluated on release).
  - timeout_now: mem_wb_flush=1 (load result discarded), dmem_timeout_o=1, no stall; lower priorities evaluated normally.
  - ex_branch_taken_i: if_id_flush=1, id_ex_flush=1, no stalls (overrides load-use; ID instruction is wrong-path).
  - load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble).
- FSM states RUN, MEM_WAIT. RUN->MEM_WAIT when mem_stall. MEM_WAIT->RUN when dmem_rvalid_i, or !mem_load_valid_i, or timeout_now. Wait counter (16 b) cleared on entry to MEM_WAIT, +1 per MEM_WAIT cycle; timeout_now = state==MEM_WAIT && TIMEOUT_CYCLES!=0 && cnt==TIMEOUT_CYCLES-1 && !dmem_rvalid_i.
- rvalid in the same cycle as timeout_now: data accepted, no timeout.

## Timing
- All stall/flush outputs combinational from inputs and state; valid in the same cycle.
- Load-use costs exactly 1 cycle: bubble enters EX next cycle, condition clears, MEM->EX forwarding then resolves.
- Load with rvalid in first MEM cycle: zero stall; FSM stays RUN.
- Timeout: first stall cycle in RUN plus TIMEOUT_CYCLES cycles in MEM_WAIT; pulse in the final one.
- Reset: state RUN, counter 0, all perf counters 0; outputs follow combinational rules (all 0 with inputs 0). Reset mid-MEM_WAIT returns to RUN immediately; no timeout pulse.

## Configuration
- RV32I_HAZARD_PERF_EN defined: perf_load_use_o +1 per load-use stall cycle, perf_mem_wait_o +1 per mem_stall cycle, perf_flush_o +1 per branch flush; 32-bit, wrap at 2^32.
- Undefined: counters not built; perf ports present, tied to 0.

## Test plan
- ex_memread=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_stall=if_id_stall=id_ex_flush=1 for one cycle; next cycle all 0; with ex_rd=0 -> no stall.
- Same load-use plus ex_branch_taken=1 -> if_id_flush=id_ex_flush=1, pc_stall=0.
- mem_load_valid=1, rvalid low 3 cycles then high -> full stall + mem_wb_flush for 3 cycles, release on 4th; perf_mem_wait_o=3 (PERF_EN).
- TIMEOUT_CYCLES=4, rvalid never -> 4 stall cycles, dmem_timeout_o pulse in 5th, mem_wb_flush=1, no stall; FSM RUN.
- mem_stall coincident with ex_branch_taken -> no flush while stalled; flush in release cycle.
- rst_ni low during MEM_WAIT -> state RUN, counter 0, perf counters 0, no timeout pulse.
